// File: rtl/shift_ctrl.sv
// shift_ctrl: sequencer for an external combinational shift datapath.
// It packs {op1,op2} into an accumulator, feeds it to the datapath through
// shift_in/shift_lines, and reloads it from shift_out for `count` passes.
// The final value is then presented on result, together with a one-cycle done pulse.
//
// Optional build macro: SHIFT_CTRL_EARLY_EXIT_EN
//   When it is defined, RUN finishes early as soon as the datapath stops changing the
//   accumulator (shift_out == acc). The port list is the same in both builds.
module shift_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [15:0]      op1,
  input  logic [15:0]      op2,
  input  logic [2:0]       sel,
  input  logic [CNT_W-1:0] count,
  output logic [31:0]      shift_in,
  output logic [2:0]       shift_lines,
  input  logic [31:0]      shift_out,
  output logic [31:0]      result,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] REM_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_reg;
  logic [31:0]       acc_reg;
  logic [2:0]        sel_reg;
  logic [CNT_W-1:0]  rem_reg;
  logic [31:0]       result_reg;
  logic              done_reg;
  logic              run_last;

  // RUN ends on the final counted pass or, in the early-exit build, at a fixed point.
`ifdef SHIFT_CTRL_EARLY_EXIT_EN
  assign run_last = (rem_reg == REM_ONE) || (shift_out == acc_reg);
`else
  assign run_last = (rem_reg == REM_ONE);
`endif

  // Control FSM and datapath registers. Operands are captured only on acceptance,
  // so input changes after acceptance cannot disturb the operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      sel_reg    <= '0;
      rem_reg    <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg <= {op1, op2};
            sel_reg <= sel;
            rem_reg <= count;
            if (count != '0) begin
              state_reg <= RUN;
            end else begin
              // A zero-pass request completes at once with the packed operands.
              state_reg  <= DONE;
              result_reg <= {op1, op2};
              done_reg   <= 1'b1;
            end
          end
        end
        RUN: begin
          acc_reg <= shift_out;
          rem_reg <= rem_reg - REM_ONE;
          if (run_last) begin
            // shift_out is the value the accumulator takes on this edge.
            state_reg  <= DONE;
            result_reg <= shift_out;
            done_reg   <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready       = (state_reg == IDLE);
  assign busy        = (state_reg == RUN) || (state_reg == DONE);
  assign shift_in    = acc_reg;
  assign shift_lines = sel_reg;
  assign result      = result_reg;
  assign done        = done_reg;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl. The shift datapath is a stub: it is either an
// increment (shift_in+1) or an identity (shift_in). The expected values are worked out by hand.
module tb_shift_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             ready;
  logic [15:0]      op1;
  logic [15:0]      op2;
  logic [2:0]       sel;
  logic [CNT_W-1:0] count;
  logic [31:0]      shift_in;
  logic [2:0]       shift_lines;
  logic [31:0]      shift_out;
  logic [31:0]      result;
  logic             done;
  logic             busy;
  logic             stub_id;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] prev_res;

  shift_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ready       (ready),
    .op1         (op1),
    .op2         (op2),
    .sel         (sel),
    .count       (count),
    .shift_in    (shift_in),
    .shift_lines (shift_lines),
    .shift_out   (shift_out),
    .result      (result),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  assign shift_out = stub_id ? shift_in : (shift_in + 32'd1);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction: the request is accepted at a rising edge. After that, done is
  // expected exp_lat edges after acceptance, counting the accepting edge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] s, input logic [CNT_W-1:0] c,
                        input int exp_lat, input logic [31:0] exp_res, input bit repulse);
    int lat;
    int extra_done;
    bit hold_err;
    @(negedge clk);
    op1 = a; op2 = b; sel = s; count = c; start = 1'b1;
    #1 check({tag, "_ready"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op1 = ~a; op2 = ~b; sel = ~s; count = ~c;
    lat = 1;
    hold_err = 1'b0;
    while (!done && lat < 100) begin
      if (shift_lines !== s || busy !== 1'b1 || result !== prev_res || ready !== 1'b0)
        hold_err = 1'b1;
      start = (repulse && lat == 5);
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, result, exp_res);
    check({tag, "_inflight"}, 32'(hold_err), 32'd0);
    check({tag, "_lines"}, 32'(shift_lines), 32'(s));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(ready), 32'd1);
    check({tag, "_hold"}, result, exp_res);
    if (repulse) begin
      extra_done = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk);
        #1;
        if (done) extra_done++;
      end
      check({tag, "_no_queue"}, 32'(extra_done), 32'd0);
    end
    prev_res = exp_res;
    $display("[TB] txn %s op=%h cnt=%0d sel=%0d lat=%0d result=%h", tag, {a, b}, c, s, lat, result);
  endtask

  initial begin
    int done_seen;
    int exp_lat_id;
    rst = 1'b1; start = 1'b0; op1 = '0; op2 = '0; sel = '0; count = '0; stub_id = 1'b0;
    prev_res = '0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_shift_in", shift_in, 32'd0);
    check("rst_lines", 32'(shift_lines), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Zero-pass request, then two back-to-back increment runs (the second runs the maximum count and gets a stray start).
    run_op("cnt0", 16'h0001, 16'h8000, 3'd4, 4'd0, 1, 32'h0001_8000, 1'b0);
    run_op("inc3", 16'h0000, 16'h0010, 3'd5, 4'd3, 4, 32'h0000_0013, 1'b0);
    run_op("inc15", 16'h0000, 16'h0010, 3'd2, 4'd15, 16, 32'h0000_001F, 1'b1);

    // Abort mid-RUN: accept count=8, let three passes happen, then reset between edges.
    @(negedge clk);
    op1 = 16'h0000; op2 = 16'h0100; sel = 3'd6; count = 4'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_shift_in", shift_in, 32'd0);
    check("abort_lines", 32'(shift_lines), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    $display("[TB] txn abort cnt=8 reset after 3 passes result=%h", result);
    prev_res = '0;
    run_op("recover", 16'h1234, 16'h0000, 3'd7, 4'd2, 3, 32'h1234_0002, 1'b0);

    // Identity datapath: the early-exit build stops at the first pass.
    stub_id = 1'b1;
`ifdef SHIFT_CTRL_EARLY_EXIT_EN
    exp_lat_id = 2;
`else
    exp_lat_id = 11;
`endif
    run_op("ident10", 16'hA5A5, 16'h5A5A, 3'd1, 4'd10, exp_lat_id, 32'hA5A5_5A5A, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Overall time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the iteration count (maximum 2^CNT_W-1 iterations).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request; accepted only when ready=1.
REQ-005 SHALL have port ready  output  1  high in IDLE only.
REQ-006 SHALL have port op1  input  16  upper operand, packed into bits [31:16].
REQ-007 SHALL have port op2  input  16  lower operand, packed into bits [15:0].
REQ-008 SHALL have port sel  input  3  shift-select code for the shift datapath.
REQ-009 SHALL have port count  input  CNT_W  number of datapath passes to apply.
REQ-010 SHALL have port shift_in  output  32  to shift datapath; equals the accumulator register.
REQ-011 SHALL have port shift_lines  output  3  to shift datapath; equals the latched sel.
REQ-012 SHALL have port shift_out  input  32  combinational result from the shift datapath.
REQ-013 SHALL have port result  output  32  final packed result, registered.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE.
REQ-017 IDLE with start=1 SHALL latch acc={op1,op2}, sel and rem=count; next state RUN if count!=0, else DONE.
REQ-018 RUN SHALL, each cycle, load acc<=shift_out and decrement rem; if rem==1, next state is DONE.
REQ-019 On every transition into DONE, result SHALL be loaded with the final acc value (the value captured on that edge when coming from RUN).
REQ-020 In DONE, done=1 for exactly one cycle; next state SHALL be IDLE unconditionally.
REQ-021 Latency: done SHALL be high in the cycle after count+1 rising edges following the accepting edge (count=0 gives 1).
REQ-022 start while ready=0 SHALL be ignored, with no queuing and no change to the latched operands.
REQ-023 result SHALL hold its value until the next entry into DONE; it SHALL NOT change in IDLE or RUN.
REQ-024 A back-to-back start SHALL be accepted in the cycle in which IDLE is re-entered, giving a minimum spacing of count+2 cycles.
REQ-025 count = 2^CNT_W-1 SHALL run exactly that many passes, with no wrap of rem.
REQ-026 Changes on op1, op2, sel and count after acceptance SHALL have no effect on the operation in flight.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, acc=0, latched sel=0, rem=0, result=0 and done=0, independent of clk.
REQ-028 While reset is held, outputs SHALL be ready=1, busy=0, shift_in=0, shift_lines=0.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no done pulse; result SHALL become 0.

Configuration
REQ-030 Macro SHIFT_CTRL_EARLY_EXIT_EN defined: in RUN, if shift_out==acc (fixed point), the next state SHALL be DONE regardless of rem, with result=acc.
REQ-031 Macro SHIFT_CTRL_EARLY_EXIT_EN undefined: RUN SHALL always perform exactly count passes; the port list SHALL be identical in both builds.

Verification
REQ-032 count=0, op1=16'h0001, op2=16'h8000, start -> done one cycle later, result=32'h00018000, shift_datapath idle.
REQ-033 Stub shift_out=shift_in+1, op1=0, op2=16'h0010, count=3 -> done after 4 cycles, result=32'h00000013, shift_lines equals sel throughout.
REQ-034 Same stub, count=15, start re-pulsed during RUN -> single done after 16 cycles, result=start+15; the second start is ignored.
REQ-035 rst asserted mid-RUN (count=8, after 3 passes) -> immediate IDLE, result=0, no done; a new start then completes normally.
REQ-036 Stub shift_out=shift_in (identity), count=10 -> with the macro, done after 2 cycles; without it, done after 11 cycles; result unchanged in both.
